// File: rtl/correlator_cmac_pipe.sv
// Pipelined complex conjugate multiply-accumulate: integrates x*conj(y) over ACC_LEN valid samples.
// Define CORRELATOR_CMAC_SAT_EN to clamp accumulators on overflow instead of wrapping.
module correlator_cmac_pipe #(
    parameter int DIN_WIDTH = 16,
    parameter int ACC_WIDTH = 48,
    parameter int NUM_STAGE = 3,
    parameter int ACC_LEN   = 256
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_sync,
    input  logic signed [DIN_WIDTH-1:0] xr,
    input  logic signed [DIN_WIDTH-1:0] xi,
    input  logic signed [DIN_WIDTH-1:0] yr,
    input  logic signed [DIN_WIDTH-1:0] yi,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_re,
    output logic signed [ACC_WIDTH-1:0] out_im,
    output logic                        out_ovf,
    output logic                        busy
);

    localparam int PROD_W = 2*DIN_WIDTH+1;
    localparam int MUL_W  = 2*DIN_WIDTH;
    localparam int CNT_W  = $clog2(ACC_LEN+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN-1);

    function automatic logic signed [MUL_W-1:0] smul(input logic signed [DIN_WIDTH-1:0] a,
                                                     input logic signed [DIN_WIDTH-1:0] b);
        logic signed [MUL_W-1:0] ae;
        logic signed [MUL_W-1:0] be;
        ae = {{DIN_WIDTH{a[DIN_WIDTH-1]}}, a};
        be = {{DIN_WIDTH{b[DIN_WIDTH-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic signed [PROD_W-1:0] sext_mul(input logic signed [MUL_W-1:0] m);
        return {m[MUL_W-1], m};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic add_ovf(input logic signed [ACC_WIDTH-1:0] a,
                                     input logic signed [ACC_WIDTH-1:0] b,
                                     input logic signed [ACC_WIDTH-1:0] s);
        return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    endfunction

`ifdef CORRELATOR_CMAC_SAT_EN
    function automatic logic signed [ACC_WIDTH-1:0] sat_clamp(input logic neg);
        return neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    // Once clamped, a component ignores further adds until the frame restarts.
    function automatic logic signed [ACC_WIDTH-1:0] acc_next(input logic signed [ACC_WIDTH-1:0] a,
                                                             input logic signed [ACC_WIDTH-1:0] s,
                                                             input logic ovf,
                                                             input logic sat);
        if (sat) return a;
        if (ovf) return sat_clamp(a[ACC_WIDTH-1]);
        return s;
    endfunction
`endif

    // Stage p0: registered input sample
    logic signed [DIN_WIDTH-1:0] xr_p0_q, xi_p0_q, yr_p0_q, yi_p0_q;
    logic signed [DIN_WIDTH-1:0] xr_p0_d, xi_p0_d, yr_p0_d, yi_p0_d;
    logic                        vld_p0_q, vld_p0_d, sync_p0_q, sync_p0_d;
    logic signed [PROD_W-1:0]    pr_p0, pi_p0;

    always_comb begin
        xr_p0_d   = xr_p0_q;
        xi_p0_d   = xi_p0_q;
        yr_p0_d   = yr_p0_q;
        yi_p0_d   = yi_p0_q;
        vld_p0_d  = vld_p0_q;
        sync_p0_d = sync_p0_q;
        if (ce) begin
            xr_p0_d   = xr;
            xi_p0_d   = xi;
            yr_p0_d   = yr;
            yi_p0_d   = yi;
            vld_p0_d  = in_valid;
            sync_p0_d = in_valid & in_sync;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p0_q  <= 1'b0;
            sync_p0_q <= 1'b0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            sync_p0_q <= sync_p0_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        xr_p0_q <= xr_p0_d;
        xi_p0_q <= xi_p0_d;
        yr_p0_q <= yr_p0_d;
        yi_p0_q <= yi_p0_d;
    end

    assign pr_p0 = sext_mul(smul(xr_p0_q, yr_p0_q)) + sext_mul(smul(xi_p0_q, yi_p0_q));
    assign pi_p0 = sext_mul(smul(xi_p0_q, yr_p0_q)) - sext_mul(smul(xr_p0_q, yi_p0_q));

    // Stages p1..p(NUM_STAGE-1): product delay line
    logic signed [PROD_W-1:0] prod_re, prod_im;
    logic                     prod_vld, prod_sync, pipe_vld_any;

    if (NUM_STAGE > 1) begin : g_dly
        localparam int ND = NUM_STAGE-1;
        logic signed [PROD_W-1:0] pr_pn_q [ND];
        logic signed [PROD_W-1:0] pr_pn_d [ND];
        logic signed [PROD_W-1:0] pi_pn_q [ND];
        logic signed [PROD_W-1:0] pi_pn_d [ND];
        logic [ND-1:0]            vld_pn_q, vld_pn_d, sync_pn_q, sync_pn_d;

        always_comb begin
            pr_pn_d   = pr_pn_q;
            pi_pn_d   = pi_pn_q;
            vld_pn_d  = vld_pn_q;
            sync_pn_d = sync_pn_q;
            if (ce) begin
                pr_pn_d[0]   = pr_p0;
                pi_pn_d[0]   = pi_p0;
                vld_pn_d[0]  = vld_p0_q;
                sync_pn_d[0] = sync_p0_q;
                for (int i = 1; i < ND; i++) begin
                    pr_pn_d[i]   = pr_pn_q[i-1];
                    pi_pn_d[i]   = pi_pn_q[i-1];
                    vld_pn_d[i]  = vld_pn_q[i-1];
                    sync_pn_d[i] = sync_pn_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                vld_pn_q  <= '0;
                sync_pn_q <= '0;
            end else begin
                vld_pn_q  <= vld_pn_d;
                sync_pn_q <= sync_pn_d;
            end
        end

        always_ff @(posedge ap_clk) begin
            pr_pn_q <= pr_pn_d;
            pi_pn_q <= pi_pn_d;
        end

        assign prod_re      = pr_pn_q[ND-1];
        assign prod_im      = pi_pn_q[ND-1];
        assign prod_vld     = vld_pn_q[ND-1];
        assign prod_sync    = sync_pn_q[ND-1];
        assign pipe_vld_any = vld_p0_q | (|vld_pn_q);
    end else begin : g_nodly
        assign prod_re      = pr_p0;
        assign prod_im      = pi_p0;
        assign prod_vld     = vld_p0_q;
        assign prod_sync    = sync_p0_q;
        assign pipe_vld_any = vld_p0_q;
    end

    // Accumulate / dump stage
    logic signed [ACC_WIDTH-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [ACC_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic signed [ACC_WIDTH-1:0] prod_re_ext, prod_im_ext, sum_re, sum_im, nxt_re, nxt_im;
    logic                        ovf_re, ovf_im;

    assign prod_re_ext = sext_prod(prod_re);
    assign prod_im_ext = sext_prod(prod_im);
    assign sum_re      = acc_re_q + prod_re_ext;
    assign sum_im      = acc_im_q + prod_im_ext;
    assign ovf_re      = add_ovf(acc_re_q, prod_re_ext, sum_re);
    assign ovf_im      = add_ovf(acc_im_q, prod_im_ext, sum_im);

`ifdef CORRELATOR_CMAC_SAT_EN
    logic sat_re_q, sat_re_d, sat_im_q, sat_im_d;
    assign nxt_re = acc_next(acc_re_q, sum_re, ovf_re, sat_re_q);
    assign nxt_im = acc_next(acc_im_q, sum_im, ovf_im, sat_im_q);
`else
    assign nxt_re = sum_re;
    assign nxt_im = sum_im;
`endif

    always_comb begin
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = ce ? 1'b0 : out_valid_q;
`ifdef CORRELATOR_CMAC_SAT_EN
        sat_re_d    = sat_re_q;
        sat_im_d    = sat_im_q;
`endif
        if (ce && prod_vld) begin
            if (prod_sync || cnt_q == '0) begin
                // A sync tag silently abandons whatever partial frame was in progress.
                acc_re_d = prod_re_ext;
                acc_im_d = prod_im_ext;
                ovf_d    = 1'b0;
                cnt_d    = CNT_W'(1);
`ifdef CORRELATOR_CMAC_SAT_EN
                sat_re_d = 1'b0;
                sat_im_d = 1'b0;
`endif
            end else if (cnt_q == LAST_CNT) begin
                out_re_d    = nxt_re;
                out_im_d    = nxt_im;
                out_ovf_d   = ovf_q | ovf_re | ovf_im;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_re_d    = nxt_re;
                acc_im_d    = nxt_im;
            end else begin
                acc_re_d = nxt_re;
                acc_im_d = nxt_im;
                ovf_d    = ovf_q | ovf_re | ovf_im;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef CORRELATOR_CMAC_SAT_EN
                sat_re_d = sat_re_q | ovf_re;
                sat_im_d = sat_im_q | ovf_im;
`endif
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CORRELATOR_CMAC_SAT_EN
            sat_re_q    <= 1'b0;
            sat_im_q    <= 1'b0;
`endif
        end else begin
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
`ifdef CORRELATOR_CMAC_SAT_EN
            sat_re_q    <= sat_re_d;
            sat_im_q    <= sat_im_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (cnt_q != '0) | pipe_vld_any;

endmodule

// File: tb/tb_correlator_cmac_pipe.sv
// Bench for correlator_cmac_pipe: frame-level reference model plus directed literal checks.
module tb_correlator_cmac_pipe;

    localparam int DW = 16;
    localparam int AW = 34;
    localparam int NS = 3;
    localparam int AL = 4;
    localparam longint ONE  = 64'sd1;
    localparam longint MAXV = (ONE <<< (AW-1)) - 1;
    localparam longint MINV = -(ONE <<< (AW-1));

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ce = 1'b1;
    logic in_valid = 1'b0;
    logic in_sync = 1'b0;
    logic signed [DW-1:0] xr = '0, xi = '0, yr = '0, yi = '0;
    logic out_valid, out_ovf, busy;
    logic signed [AW-1:0] out_re, out_im;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    correlator_cmac_pipe #(
        .DIN_WIDTH(DW), .ACC_WIDTH(AW), .NUM_STAGE(NS), .ACC_LEN(AL)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_sync(in_sync),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf), .busy(busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: frame arithmetic on plain integers, products delivered NS enabled edges after acceptance.
    typedef struct {longint due; bit sync; longint pr; longint pi;} ent_t;
    ent_t   pend_q[$];
    ent_t   m_e;
    longint eidx = 0, m_cnt = 0, acc_re = 0, acc_im = 0;
    bit     m_ovf = 0, sat_re = 0, sat_im = 0, o_re, o_im;
    bit     exp_valid = 0, exp_ovf = 0, exp_busy = 0;
    longint exp_re = 0, exp_im = 0;

    function automatic longint wrapv(input longint s);
        longint m;
        m = s & ((ONE <<< AW) - 1);
        if (m > MAXV) m = m - (ONE <<< AW);
        return m;
    endfunction

    function automatic longint madd(input longint a, input longint b, input bit sat_in,
                                    output bit o, output bit sat_out);
        longint s;
        s = a + b;
        o = (s > MAXV) || (s < MINV);
`ifdef CORRELATOR_CMAC_SAT_EN
        sat_out = sat_in || o;
        if (sat_in) return a;
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
`else
        sat_out = sat_in;
        return wrapv(s);
`endif
    endfunction

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pend_q.delete();
            eidx = 0; m_cnt = 0; acc_re = 0; acc_im = 0;
            m_ovf = 0; sat_re = 0; sat_im = 0;
            exp_valid = 0; exp_ovf = 0; exp_busy = 0; exp_re = 0; exp_im = 0;
        end else if (ce) begin
            exp_valid = 0;
            while (pend_q.size() > 0 && pend_q[0].due == eidx) begin
                m_e = pend_q.pop_front();
                if (m_e.sync || m_cnt == 0) begin
                    acc_re = m_e.pr; acc_im = m_e.pi;
                    m_ovf = 0; sat_re = 0; sat_im = 0; m_cnt = 1;
                end else begin
                    acc_re = madd(acc_re, m_e.pr, sat_re, o_re, sat_re);
                    acc_im = madd(acc_im, m_e.pi, sat_im, o_im, sat_im);
                    m_ovf = m_ovf | o_re | o_im;
                    m_cnt++;
                    if (m_cnt == AL) begin
                        exp_valid = 1; exp_re = acc_re; exp_im = acc_im; exp_ovf = m_ovf;
                        m_cnt = 0;
                    end
                end
            end
            if (in_valid)
                pend_q.push_back('{eidx + NS, in_sync,
                                   longint'(xr) * longint'(yr) + longint'(xi) * longint'(yi),
                                   longint'(xi) * longint'(yr) - longint'(xr) * longint'(yi)});
            eidx++;
            exp_busy = (pend_q.size() != 0) || (m_cnt != 0);
        end
    end

    typedef struct {longint re; longint im; bit ovf; int cyc;} cap_t;
    cap_t cap_q[$];

    always @(negedge ap_clk) begin
        chk("out_valid", longint'(out_valid), longint'(exp_valid));
        chk("busy", longint'(busy), longint'(exp_busy));
        chk("out_re", longint'(out_re), exp_re);
        chk("out_im", longint'(out_im), exp_im);
        chk("out_ovf", longint'(out_ovf), longint'(exp_ovf));
        if (out_valid) cap_q.push_back('{longint'(out_re), longint'(out_im), out_ovf, cyc});
    end

    task automatic step(input bit v, input bit s, input bit c,
                        input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic signed [DW-1:0] d, input logic signed [DW-1:0] e);
        in_valid = v; in_sync = s; ce = c;
        xr = a; xi = b; yr = d; yi = e;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    function automatic logic signed [DW-1:0] rnd();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -16'sd32768;
        if (r == 1) return 16'sd32767;
        return DW'($urandom);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int t_last;
    longint sat_exp;

    initial begin
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_re", longint'(out_re), 0);
        chk("rst_busy", longint'(busy), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // 3+4j times conj(3+4j) = 25 per sample
        cap_q.delete();
        repeat (4) step(1, 0, 1, 3, 4, 3, 4);
        t_last = cyc;
        idle(12);
        chk("t1_dumps", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t1_re", cap_q[0].re, 100);
            chk("t1_im", cap_q[0].im, 0);
            chk("t1_ovf", cap_q[0].ovf, 0);
            chk("t1_latency", cap_q[0].cyc - t_last + 1, NS + 1);
        end

        // x=1, y=j then x=j, y=1, back to back
        cap_q.delete();
        repeat (4) step(1, 0, 1, 1, 0, 0, 1);
        repeat (4) step(1, 0, 1, 0, 1, 1, 0);
        idle(12);
        chk("t2_dumps", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("t2_re0", cap_q[0].re, 0);
            chk("t2_im0", cap_q[0].im, -4);
            chk("t2_im1", cap_q[1].im, 4);
            chk("t2_spacing", cap_q[1].cyc - cap_q[0].cyc, AL);
        end

        // ce freeze and bubbles inside a frame
        cap_q.delete();
        repeat (2) step(1, 0, 1, 3, 4, 3, 4);
        repeat (5) step(1, 1, 0, rnd(), rnd(), rnd(), rnd());
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 3, 4, 3, 4);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 3, 4, 3, 4);
        t_last = cyc;
        idle(12);
        chk("t3_dumps", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t3_re", cap_q[0].re, 100);
            chk("t3_latency", cap_q[0].cyc - t_last + 1, NS + 1);
        end

        // sync on sample 3 restarts the frame
        cap_q.delete();
        repeat (2) step(1, 0, 1, 5, 0, 1, 0);
        step(1, 1, 1, 3, 4, 3, 4);
        repeat (3) step(1, 0, 1, 3, 4, 3, 4);
        t_last = cyc;
        idle(12);
        chk("t4_dumps", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t4_re", cap_q[0].re, 100);
            chk("t4_latency", cap_q[0].cyc - t_last + 1, NS + 1);
        end

        // most-negative inputs: 4 * 2^31 = 2^33 overflows a 34-bit accumulator
        cap_q.delete();
        repeat (4) step(1, 0, 1, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        idle(12);
`ifdef CORRELATOR_CMAC_SAT_EN
        sat_exp = 64'sd8589934591;
`else
        sat_exp = -64'sd8589934592;
`endif
        chk("t5_dumps", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t5_re", cap_q[0].re, sat_exp);
            chk("t5_im", cap_q[0].im, 0);
            chk("t5_ovf", cap_q[0].ovf, 1);
        end

        // asynchronous reset mid-frame
        cap_q.delete();
        repeat (2) step(1, 0, 1, 3, 4, 3, 4);
        #2;
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_async_re", longint'(out_re), 0);
        chk("t6_async_ovf", longint'(out_ovf), 0);
        chk("t6_async_busy", longint'(busy), 0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        repeat (4) step(1, 0, 1, 3, 4, 3, 4);
        idle(12);
        chk("t6_dumps", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t6_re", cap_q[0].re, 100);
            chk("t6_ovf", cap_q[0].ovf, 0);
        end

        // randomized traffic against the model
        repeat (600) begin
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 85,
                 rnd(), rnd(), rnd(), rnd());
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
